// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command stream to APB SETUP/ACCESS transfers, one-hot PSELx from addr[31:28]; APB_TIMEOUT_EN adds an ACCESS wait limit.
// Latency: accept at edge N -> SETUP N+1, ACCESS N+2, rsp_valid in N+3 with zero waits; decode errors respond in N+1.
// Backpressure: one transfer outstanding; cmd_ready stays low until the response handshakes on rsp_ready.
module apb_master_bridge #(
   parameter int SLV_NUM        = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  PCLK,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [31:0]           cmd_addr,
   input  logic [31:0]           cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_error,
   output logic [31:0]           PADDR,
   output logic [31:0]           PWDATA,
   output logic                  PWRITE,
   output logic [SLV_NUM-1:0]    PSELx,
   output logic                  PENABLE,
   input  logic [32*SLV_NUM-1:0] PRDATA,
   input  logic [SLV_NUM-1:0]    PREADY
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t             r_state;
   logic [SLV_NUM-1:0] w_dec_sel;
   logic               w_dec_ok;
   logic               w_pready;
   logic [31:0]        w_prdata;
   logic               w_timeout;

   generate
      if (SLV_NUM < 1 || SLV_NUM > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
         $error("apb_master_bridge: SLV_NUM or TIMEOUT_CYCLES out of range");
      end
   endgenerate

   assign cmd_ready = (r_state == IDLE) && !reset;

   always_comb begin
      w_dec_sel = '0;
      for (int i = 0; i < SLV_NUM; i++) begin
         w_dec_sel[i] = (cmd_addr[31:28] == 4'(i));
      end
   end

   assign w_dec_ok = |w_dec_sel;

   // The registered one-hot select doubles as the read-data/ready mux, so other slots are ignored.
   always_comb begin
      w_pready = 1'b0;
      w_prdata = '0;
      for (int i = 0; i < SLV_NUM; i++) begin
         if (PSELx[i]) begin
            w_pready = PREADY[i];
            w_prdata = PRDATA[32*i +: 32];
         end
      end
   end

`ifdef APB_TIMEOUT_EN
   localparam int WAIT_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;

   logic [WAIT_W-1:0] r_wait_cnt;

   always_ff @(posedge PCLK) begin
      if (reset) begin
         r_wait_cnt <= '0;
      end else if (r_state != ACCESS) begin
         r_wait_cnt <= '0;
      end else if (!w_pready) begin
         r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end
   end

   assign w_timeout = (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES)) && !w_pready;
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge PCLK) begin
      if (reset) begin
         r_state   <= IDLE;
         PSELx     <= '0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_error <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  PADDR  <= cmd_addr;
                  PWDATA <= cmd_wdata;
                  PWRITE <= cmd_write;
                  if (w_dec_ok) begin
                     PSELx   <= w_dec_sel;
                     r_state <= SETUP;
                  end else begin
                     rsp_rdata <= '0;
                     rsp_error <= 1'b1;
                     rsp_valid <= 1'b1;
                     r_state   <= RESP;
                  end
               end
            end
            SETUP: begin
               PENABLE <= 1'b1;
               r_state <= ACCESS;
            end
            ACCESS: begin
               // Ready on the limit cycle still completes normally.
               if (w_pready) begin
                  rsp_rdata <= PWRITE ? 32'd0 : w_prdata;
                  rsp_error <= 1'b0;
                  rsp_valid <= 1'b1;
                  PSELx     <= '0;
                  PENABLE   <= 1'b0;
                  r_state   <= RESP;
               end else if (w_timeout) begin
                  rsp_rdata <= '0;
                  rsp_error <= 1'b1;
                  rsp_valid <= 1'b1;
                  PSELx     <= '0;
                  PENABLE   <= 1'b0;
                  r_state   <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: table vectors, hand-written reset sequences and random transfers against a spec model.
module tb_apb_master_bridge;

   localparam int SLV = 4;

   logic              PCLK = 1'b0;
   logic              reset;
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [31:0]       cmd_addr;
   logic [31:0]       cmd_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_rdata;
   logic              rsp_error;
   logic [31:0]       PADDR;
   logic [31:0]       PWDATA;
   logic              PWRITE;
   logic [SLV-1:0]    PSELx;
   logic              PENABLE;
   logic [32*SLV-1:0] PRDATA;
   logic [SLV-1:0]    PREADY;

   int total = 0;
   int bad   = 0;

   always #5 PCLK = ~PCLK;

   apb_master_bridge #(.SLV_NUM(SLV), .TIMEOUT_CYCLES(255)) dut (
      .PCLK      (PCLK),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_error (rsp_error),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PWRITE    (PWRITE),
      .PSELx     (PSELx),
      .PENABLE   (PENABLE),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY)
   );

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] prdata;
      int          waits;
      int          hold;
      bit          early;
      logic [31:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t model(input vec_t v);
      vec_t r;
      r = v;
      r.exp_err   = (int'(v.addr[31:28]) >= SLV);
      r.exp_rdata = (r.exp_err || v.wr) ? 32'd0 : v.prdata;
      return r;
   endfunction

   // Entered and left at a negedge with the bridge idle.
   task automatic run(input vec_t v);
      int             slot;
      int             lat;
      logic [SLV-1:0] sel;
      slot = int'(v.addr[31:28]);
      sel  = '0;
      if (slot < SLV) sel[slot] = 1'b1;
      lat  = (slot < SLV) ? 3 + v.waits : 1;

      chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_write = v.wr;
      cmd_addr  = v.addr;
      cmd_wdata = v.wdata;
      rsp_ready = v.early;
      for (int i = 0; i < SLV; i++) PRDATA[32*i +: 32] = $urandom;
      if (slot < SLV) PRDATA[32*slot +: 32] = v.prdata;
      PREADY = SLV'($urandom) & ~sel;
      @(negedge PCLK);
      cmd_valid = 1'b0;
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      cmd_write = ~v.wr;

      for (int c = 1; c < lat; c++) begin
         chk("rsp_valid_busy", 32'(rsp_valid), 32'd0);
         chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
         chk("psel_phase", 32'(PSELx), 32'(sel));
         chk("penable_phase", 32'(PENABLE), 32'(c >= 2));
         chk("paddr_stable", PADDR, v.addr);
         chk("pwdata_stable", PWDATA, v.wdata);
         chk("pwrite_stable", 32'(PWRITE), 32'(v.wr));
         PREADY = (SLV'($urandom) & ~sel) | ((c == 2 + v.waits) ? sel : '0);
         @(negedge PCLK);
      end

      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_rdata", rsp_rdata, v.exp_rdata);
      chk("rsp_error", 32'(rsp_error), 32'(v.exp_err));
      chk("psel_resp", 32'(PSELx), 32'd0);
      chk("penable_resp", 32'(PENABLE), 32'd0);
      chk("cmd_ready_resp", 32'(cmd_ready), 32'd0);
      chk("paddr_latched", PADDR, v.addr);
      PREADY = SLV'($urandom);

      if (!v.early) begin
         for (int h = 0; h < v.hold; h++) begin
            cmd_valid = 1'b1;
            cmd_addr  = $urandom;
            @(negedge PCLK);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_rdata", rsp_rdata, v.exp_rdata);
            chk("hold_rsp_error", 32'(rsp_error), 32'(v.exp_err));
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("hold_no_accept", PADDR, v.addr);
            chk("hold_psel", 32'(PSELx), 32'd0);
         end
         cmd_valid = 1'b0;
         rsp_ready = 1'b1;
      end
      @(negedge PCLK);
      chk("rsp_valid_done", 32'(rsp_valid), 32'd0);
      chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
      chk("paddr_idle_hold", PADDR, v.addr);
      rsp_ready = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [8];
      vec_t v;

      tbl[0] = '{1'b0, 32'h1000_0004, 32'h0000_0000, 32'hA5A5_0001, 0, 0, 1'b1, 32'hA5A5_0001, 1'b0};
      tbl[1] = '{1'b1, 32'h0000_0010, 32'h0000_0041, 32'hDEAD_BEEF, 3, 0, 1'b0, 32'h0000_0000, 1'b0};
      tbl[2] = '{1'b0, 32'h7000_0000, 32'h0000_0000, 32'h1111_2222, 0, 0, 1'b0, 32'h0000_0000, 1'b1};
      tbl[3] = '{1'b0, 32'h3000_0100, 32'h0000_0000, 32'h1234_5678, 1, 5, 1'b0, 32'h1234_5678, 1'b0};
      tbl[4] = '{1'b0, 32'h4000_0000, 32'h0000_0000, 32'h5555_AAAA, 0, 1, 1'b0, 32'h0000_0000, 1'b1};
      tbl[5] = '{1'b1, 32'hF000_0000, 32'hCAFE_F00D, 32'h0BAD_0BAD, 0, 2, 1'b0, 32'h0000_0000, 1'b1};
      tbl[6] = '{1'b0, 32'h2FFF_FFFC, 32'h0000_0000, 32'hFFFF_FFFF, 0, 1, 1'b0, 32'hFFFF_FFFF, 1'b0};
      tbl[7] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h8000_0001, 7, 0, 1'b0, 32'h8000_0001, 1'b0};

      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      rsp_ready = 1'b0;
      PRDATA    = '0;
      PREADY    = '0;

      @(negedge PCLK);
      chk("rst_psel", 32'(PSELx), 32'd0);
      chk("rst_penable", 32'(PENABLE), 32'd0);
      chk("rst_pwrite", 32'(PWRITE), 32'd0);
      chk("rst_paddr", PADDR, 32'd0);
      chk("rst_pwdata", PWDATA, 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_error", 32'(rsp_error), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      reset = 1'b0;
      @(negedge PCLK);
      chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

      for (int i = 0; i < 8; i++) run(tbl[i]);

      // Reset while in ACCESS with the responder stalled.
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h1000_0000;
      PREADY    = '0;
      @(negedge PCLK);
      cmd_valid = 1'b0;
      @(negedge PCLK);
      chk("midacc_penable", 32'(PENABLE), 32'd1);
      chk("midacc_psel", 32'(PSELx), 32'h2);
      reset = 1'b1;
      @(negedge PCLK);
      chk("midacc_rst_psel", 32'(PSELx), 32'd0);
      chk("midacc_rst_penable", 32'(PENABLE), 32'd0);
      chk("midacc_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midacc_rst_cmd_ready", 32'(cmd_ready), 32'd0);
      reset = 1'b0;
      @(negedge PCLK);
      chk("midacc_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("midacc_rsp_valid", 32'(rsp_valid), 32'd0);

      // Reset while a response is pending discards it.
      cmd_valid = 1'b1;
      cmd_addr  = 32'h9000_0000;
      @(negedge PCLK);
      cmd_valid = 1'b0;
      chk("resp_pending", 32'(rsp_valid), 32'd1);
      reset = 1'b1;
      @(negedge PCLK);
      chk("resp_rst_valid", 32'(rsp_valid), 32'd0);
      chk("resp_rst_error", 32'(rsp_error), 32'd0);
      reset = 1'b0;
      @(negedge PCLK);
      chk("resp_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("resp_rst_still_empty", 32'(rsp_valid), 32'd0);

      for (int n = 0; n < 40; n++) begin
         logic [3:0] s;
         s        = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, SLV - 1));
         v.wr     = 1'($urandom_range(0, 1));
         v.addr   = {s, 28'($urandom)};
         v.wdata  = $urandom;
         v.prdata = $urandom;
         v.waits  = $urandom_range(0, 4);
         v.hold   = $urandom_range(0, 3);
         v.early  = 1'($urandom_range(0, 1));
         v        = model(v);
         run(v);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB initiator that turns a simple valid/ready command stream (from a CPU model or test sequencer) into APB SETUP/ACCESS transfers.
- Drives up to SLV_NUM responders, such as the UART APB peripheral, through one-hot PSELx decoding.
- Returns read data and a completion/error status on a valid/ready response channel.
- Sits between the system's bus-master logic and the APB peripheral fabric.

Parameters:
- SLV_NUM, 4, number of APB responders; PSELx width; slot index = cmd_addr[31:28]; legal range 1..16.
- TIMEOUT_CYCLES, 255, wait-state limit for ACCESS; used only when APB_TIMEOUT_EN is defined.

Ports:
- PCLK  input  1  bus clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  bridge accepts command this cycle.
- cmd_write  input  1  1=write, 0=read.
- cmd_addr  input  32  target address; [31:28] selects the slot.
- cmd_wdata  input  32  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed.
- rsp_rdata  output  32  read data; 0 for writes.
- rsp_error  output  1  decode error or timeout.
- PADDR  output  32  APB address.
- PWDATA  output  32  APB write data.
- PWRITE  output  1  APB direction.
- PSELx  output  SLV_NUM  one-hot responder select.
- PENABLE  output  1  APB access phase.
- PRDATA  input  32*SLV_NUM  flattened read data; slot i occupies bits [32i+31:32i].
- PREADY  input  SLV_NUM  per-slot ready.

Behaviour:
- Clock and reset: single clock domain, PCLK. Reset is synchronous and active-high on reset.
- Reset values (first edge with reset=1):
  - state=IDLE.
  - PSELx=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
  - rsp_valid=0, rsp_rdata=0, rsp_error=0.
  - cmd_ready=1 from the following cycle.
- Reset mid-transfer: drops PSELx/PENABLE at that edge and discards any pending response.
- States are IDLE, SETUP, ACCESS, RESP.
- cmd_ready = (state==IDLE) && !reset. It is combinational from state.
- IDLE, on cmd_valid && cmd_ready:
  - Latch PADDR=cmd_addr, PWDATA=cmd_wdata, PWRITE=cmd_write, slot=cmd_addr[31:28].
  - If slot < SLV_NUM: PSELx[slot]=1, go to SETUP.
  - Otherwise: PSELx stays 0, set rsp_error=1 and rsp_rdata=0, go to RESP. No bus activity.
- SETUP: lasts exactly 1 cycle. PENABLE=1 at the next edge, then go to ACCESS.
- ACCESS: PSELx and PENABLE held; PADDR, PWDATA and PWRITE are stable throughout.
- ACCESS, when PREADY[slot]=1:
  - Capture rsp_rdata = PWRITE ? 0 : PRDATA[slot]; set rsp_error=0.
  - Clear PSELx/PENABLE at the same edge and go to RESP.
- ACCESS, when PREADY[slot]=0: stay in ACCESS (wait state). There is no limit unless the optional feature is enabled.
- PREADY on non-selected slots is ignored.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_error are held stable until rsp_ready.
  - On rsp_valid && rsp_ready: clear rsp_valid, go to IDLE.
  - rsp_ready asserted before rsp_valid has no effect.
- PADDR, PWDATA and PWRITE keep their last values in IDLE. PSELx and PENABLE are 0 outside SETUP/ACCESS.
- Latency:
  - Command accepted at edge N. SETUP occupies cycle N+1, ACCESS cycle N+2.
  - With zero wait states, rsp_valid is seen in cycle N+3.
  - If rsp_ready is already high, the next command can be accepted at edge N+4.
- Exactly one outstanding transfer at a time; no pipelining.
- PENABLE is never asserted without a PSELx bit.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit wait counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY[slot]=0.
  - When the counter equals TIMEOUT_CYCLES and PREADY is still 0: clear PSELx/PENABLE, set rsp_rdata=0 and rsp_error=1, go to RESP.
  - PREADY=1 on the same cycle as the limit wins: normal completion.
- Not defined: no counter logic; ACCESS waits indefinitely; rsp_error is set only by decode errors.

Test Plan:
- Read, zero wait: cmd read addr 0x1000_0004, PRDATA slot1=0xA5A5_0001, PREADY[1]=1 -> PSELx=4'b0010 for 2 cycles, PENABLE only in the 2nd; rsp_valid 3 cycles after accept; rsp_rdata=0xA5A5_0001, rsp_error=0.
- Write, 3 wait states: cmd write addr 0x0000_0010 data 0x0000_0041, PREADY[0] low 3 ACCESS cycles -> PADDR/PWDATA/PWRITE=1 stable for 5 cycles; rsp_rdata=0, rsp_error=0.
- Decode error: cmd addr 0x7000_0000 with SLV_NUM=4 -> PSELx stays 0, PENABLE stays 0; rsp_valid next cycle with rsp_error=1.
- Response backpressure: rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata held; cmd_ready=0; new cmd_valid is not accepted until the cycle after the handshake.
- Reset mid-ACCESS: assert reset while PENABLE=1 -> next edge PSELx=0, PENABLE=0, rsp_valid=0; cmd_ready=1 the following cycle.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY stuck 0 -> PSELx drops after 4 wait cycles; rsp_error=1, rsp_rdata=0.
